// File: rtl/hdc_class_trainer_if.sv
// Stream/command bus of the HDC class trainer: encoder element stream in,
// accumulator dump stream out, plus status.
interface hdc_class_trainer_if #(
   parameter int ACC_W = 16,
   parameter int CNT_W = 16
);
   logic                    clear_start;
   logic                    dump_start;
   logic                    dump_class;
   logic                    in_valid;
   logic                    in_ready;
   logic [1:0]              in_elem;
   logic                    in_label;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_data;
   logic                    out_last;
   logic                    busy;
   logic                    bad_elem;
   logic [CNT_W-1:0]        cnt_ham;
   logic [CNT_W-1:0]        cnt_spam;

   modport master (
      output clear_start, dump_start, dump_class, in_valid, in_elem, in_label, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy, bad_elem, cnt_ham, cnt_spam
   );

   modport slave (
      input  clear_start, dump_start, dump_class, in_valid, in_elem, in_label, out_ready,
      output in_ready, out_valid, out_data, out_last, busy, bad_elem, cnt_ham, cnt_spam
   );
endinterface

// File: rtl/hdc_class_trainer.sv
// Bundles ternary message hypervectors into per-class (ham/spam) saturating
// accumulators and streams a class accumulator back out on request.
module hdc_class_trainer #(
   parameter int DIM   = 10000,
   parameter int ACC_W = 16,
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               rst,
   hdc_class_trainer_if.slave bus
);

   localparam int                    IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [IDX_W-1:0]      LAST  = IDX_W'(DIM - 1);
   localparam logic signed [ACC_W:0] SMAX  = (ACC_W + 1)'((2 ** (ACC_W - 1)) - 1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_TRAIN, S_DUMP} state_t;

   state_t                  r_state, w_state_nxt;
   logic [IDX_W-1:0]        r_idx;
   logic                    r_lab;
   logic                    r_dcls;
   logic                    r_out_valid;
   logic                    r_out_last;
   logic signed [ACC_W-1:0] r_out_data;
   logic                    r_bad;
   logic [CNT_W-1:0]        r_cnt_ham;
   logic [CNT_W-1:0]        r_cnt_spam;

   // Accumulator storage is deliberately left without reset; CLEAR initialises it.
   logic signed [ACC_W-1:0] r_acc_ham  [DIM];
   logic signed [ACC_W-1:0] r_acc_spam [DIM];

   logic                    w_in_ready, w_accept, w_xfer, w_is_last, w_clr_we;
   logic                    w_trn_cls, w_dmp_cls;
   logic [IDX_W-1:0]        w_idx_inc, w_dmp_addr;
   logic signed [1:0]       w_e;
   logic signed [ACC_W-1:0] w_trn_old, w_trn_new, w_dmp_rd;

   // Symmetric clamp keeps the most negative code out of the accumulators.
   function automatic logic signed [ACC_W-1:0] f_sat(input logic signed [ACC_W-1:0] a,
                                                     input logic signed [1:0] e);
      logic signed [ACC_W:0] s;
      s = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W - 1){e[1]}}, e});
      if (s > SMAX)
         s = SMAX;
      else if (s < -SMAX)
         s = -SMAX;
      return s[ACC_W-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_clr_we    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = !bus.clear_start && !bus.dump_start;
            if (bus.clear_start)
               w_state_nxt = S_CLEAR;
            else if (bus.dump_start)
               w_state_nxt = S_DUMP;
            else if (bus.in_valid && (DIM > 1))
               w_state_nxt = S_TRAIN;
         end
         S_CLEAR: begin
            w_clr_we = 1'b1;
            if (w_is_last)
               w_state_nxt = S_IDLE;
         end
         S_TRAIN: begin
            w_in_ready = 1'b1;
            if (bus.in_valid && w_is_last)
               w_state_nxt = S_IDLE;
         end
         S_DUMP: begin
            if (w_xfer && w_is_last)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_xfer     = r_out_valid && bus.out_ready;
   assign w_is_last  = (r_idx == LAST);
   assign w_idx_inc  = r_idx + IDX_W'(1);
   assign w_e        = (bus.in_elem == 2'b01) ? 2'sb01 :
                       (bus.in_elem == 2'b11) ? 2'sb11 : 2'sb00;

   // Element 0 arrives in IDLE, so its class comes straight from the input label.
   assign w_trn_cls  = (r_state == S_IDLE) ? bus.in_label : r_lab;
   assign w_trn_old  = w_trn_cls ? r_acc_ham[r_idx] : r_acc_spam[r_idx];
   assign w_trn_new  = f_sat(w_trn_old, w_e);

   // Prefetch the next dump word: element 0 on start, idx+1 on each transfer.
   assign w_dmp_cls  = (r_state == S_IDLE) ? bus.dump_class : r_dcls;
   assign w_dmp_addr = (r_state == S_IDLE) ? '0 : w_idx_inc;
   assign w_dmp_rd   = w_dmp_cls ? r_acc_ham[w_dmp_addr] : r_acc_spam[w_dmp_addr];

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_acc_ham[r_idx]  <= '0;
         r_acc_spam[r_idx] <= '0;
      end else if (w_accept) begin
         if (w_trn_cls)
            r_acc_ham[r_idx]  <= w_trn_new;
         else
            r_acc_spam[r_idx] <= w_trn_new;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx       <= '0;
         r_lab       <= 1'b0;
         r_dcls      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_bad       <= 1'b0;
         r_cnt_ham   <= '0;
         r_cnt_spam  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.clear_start) begin
                  r_idx      <= '0;
                  r_bad      <= 1'b0;
                  r_cnt_ham  <= '0;
                  r_cnt_spam <= '0;
               end else if (bus.dump_start) begin
                  r_dcls      <= bus.dump_class;
                  r_idx       <= '0;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_dmp_rd;
                  r_out_last  <= (DIM == 1);
               end else if (bus.in_valid) begin
                  r_lab <= bus.in_label;
                  if (bus.in_elem == 2'b10)
                     r_bad <= 1'b1;
                  if (DIM == 1) begin
                     if (bus.in_label)
                        r_cnt_ham  <= f_inc(r_cnt_ham);
                     else
                        r_cnt_spam <= f_inc(r_cnt_spam);
                  end else begin
                     r_idx <= IDX_W'(1);
                  end
               end
            end
            S_CLEAR: begin
               r_idx <= w_is_last ? '0 : w_idx_inc;
            end
            S_TRAIN: begin
               if (bus.in_valid) begin
                  if (bus.in_elem == 2'b10)
                     r_bad <= 1'b1;
                  if (w_is_last) begin
                     r_idx <= '0;
                     if (r_lab)
                        r_cnt_ham  <= f_inc(r_cnt_ham);
                     else
                        r_cnt_spam <= f_inc(r_cnt_spam);
                  end else begin
                     r_idx <= w_idx_inc;
                  end
               end
            end
            S_DUMP: begin
               if (w_xfer) begin
                  if (w_is_last) begin
                     r_idx       <= '0;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                  end else begin
                     r_idx      <= w_idx_inc;
                     r_out_data <= w_dmp_rd;
                     r_out_last <= (w_idx_inc == LAST);
                  end
               end
            end
            default: r_idx <= '0;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.bad_elem  = r_bad;
   assign bus.cnt_ham   = r_cnt_ham;
   assign bus.cnt_spam  = r_cnt_spam;

endmodule

// File: tb/tb_hdc_class_trainer.sv
// Directed bench for hdc_class_trainer at DIM=8, ACC_W=4 (small enough to hit saturation).
module tb_hdc_class_trainer;
   localparam int DIM   = 8;
   localparam int ACC_W = 4;
   localparam int CNT_W = 16;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   hdc_class_trainer_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
   hdc_class_trainer #(.DIM(DIM), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear(input string tag);
      int n;
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      n = 0;
      while (bus.busy && n < 20) begin
         n++;
         tick();
      end
      chk(tag, n, 8);
   endtask

   // Label only valid on element 0; later elements carry the opposite label on purpose.
   task automatic send_hv(input logic lab, input logic [1:0] c[8], input int gap);
      for (int j = 0; j < 8; j++) begin
         if (j == gap) begin
            bus.in_valid = 1'b0;
            tick();
         end
         bus.in_valid = 1'b1;
         bus.in_elem  = c[j];
         bus.in_label = (j == 0) ? lab : ~lab;
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic dump_chk(input string tag, input logic cls, input int e[8], input bit stall);
      int k;
      int cyc;
      bit xfer;
      bus.dump_class = cls;
      bus.dump_start = 1'b1;
      tick();
      bus.dump_start = 1'b0;
      bus.dump_class = ~cls;
      chk({tag, "_lat"}, bus.out_valid, 1);
      k   = 0;
      cyc = 0;
      while (k < 8 && cyc < 60) begin
         bus.in_valid  = 1'b1;
         bus.in_elem   = 2'b01;
         bus.out_ready = stall ? (cyc % 3 == 0) : 1'b1;
         #1;
         chk({tag, "_inrdy"}, bus.in_ready, 0);
         chk({tag, "_vld"}, bus.out_valid, 1);
         chk({tag, "_data"}, $signed(bus.out_data), e[k]);
         chk({tag, "_last"}, bus.out_last, (k == 7));
         xfer = bus.out_valid && bus.out_ready;
         tick();
         if (xfer) k++;
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk({tag, "_count"}, k, 8);
      chk({tag, "_endvld"}, bus.out_valid, 0);
      chk({tag, "_endbusy"}, bus.busy, 0);
   endtask

   initial begin
      logic [1:0] c[8];
      int         e[8];
      int         n;

      rst = 1'b0;
      bus.clear_start = 1'b0;
      bus.dump_start  = 1'b0;
      bus.dump_class  = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_elem     = 2'b00;
      bus.in_label    = 1'b0;
      bus.out_ready   = 1'b0;
      #2 rst = 1'b1;
      #2;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", $signed(bus.out_data), 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_bad", bus.bad_elem, 0);
      chk("rst_cnt_ham", bus.cnt_ham, 0);
      chk("rst_cnt_spam", bus.cnt_spam, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // One ham HV of all +1
      do_clear("clr0_busy");
      c = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      send_hv(1'b1, c, -1);
      chk("A_cnt_ham", bus.cnt_ham, 1);
      chk("A_cnt_spam", bus.cnt_spam, 0);
      e = '{1, 1, 1, 1, 1, 1, 1, 1};
      dump_chk("A_ham", 1'b1, e, 1'b0);

      // Mixed spam pattern twice (second with a gap), ham all -1 once
      do_clear("clr1_busy");
      chk("B_cnt_ham_clr", bus.cnt_ham, 0);
      c = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11};
      send_hv(1'b0, c, -1);
      send_hv(1'b0, c, 3);
      c = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
      send_hv(1'b1, c, -1);
      chk("B_cnt_ham", bus.cnt_ham, 1);
      chk("B_cnt_spam", bus.cnt_spam, 2);
      e = '{2, -2, 0, 2, -2, 0, 2, -2};
      dump_chk("B_spam", 1'b0, e, 1'b1);
      e = '{-1, -1, -1, -1, -1, -1, -1, -1};
      dump_chk("B_ham", 1'b1, e, 1'b0);

      // Saturation at +7 then -7 with 4-bit accumulators
      do_clear("clr2_busy");
      c = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      repeat (9) send_hv(1'b1, c, -1);
      e = '{7, 7, 7, 7, 7, 7, 7, 7};
      dump_chk("C_pos", 1'b1, e, 1'b0);
      c = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
      repeat (16) send_hv(1'b1, c, -1);
      e = '{-7, -7, -7, -7, -7, -7, -7, -7};
      dump_chk("C_neg", 1'b1, e, 1'b1);
      chk("C_cnt_ham", bus.cnt_ham, 25);
      chk("C_cnt_spam", bus.cnt_spam, 0);

      // Clear wins over dump and a same-cycle element
      bus.clear_start = 1'b1;
      bus.dump_start  = 1'b1;
      bus.dump_class  = 1'b1;
      bus.in_valid    = 1'b1;
      bus.in_elem     = 2'b01;
      bus.in_label    = 1'b1;
      #1;
      chk("D_in_ready", bus.in_ready, 0);
      tick();
      bus.clear_start = 1'b0;
      bus.dump_start  = 1'b0;
      bus.in_valid    = 1'b0;
      n = 0;
      while (bus.busy && n < 20) begin
         chk("D_out_valid_clr", bus.out_valid, 0);
         n++;
         tick();
      end
      chk("D_busy_cycles", n, 8);
      chk("D_cnt_ham", bus.cnt_ham, 0);

      // Illegal code 10 flags bad_elem and adds nothing
      chk("D_bad_pre", bus.bad_elem, 0);
      c = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      send_hv(1'b0, c, -1);
      chk("D_bad_set", bus.bad_elem, 1);
      e = '{1, 1, 0, 1, 1, 1, 1, 1};
      dump_chk("D_spam", 1'b0, e, 1'b0);
      chk("D_bad_sticky", bus.bad_elem, 1);
      do_clear("clr3_busy");
      chk("D_bad_cleared", bus.bad_elem, 0);

      // Reset in the middle of a ham HV
      c = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      for (int j = 0; j < 4; j++) begin
         bus.in_valid = 1'b1;
         bus.in_elem  = 2'b01;
         bus.in_label = 1'b1;
         tick();
      end
      chk("E_busy_mid", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("E_cnt_ham", bus.cnt_ham, 0);
      chk("E_in_ready", bus.in_ready, 1);
      chk("E_out_valid", bus.out_valid, 0);
      chk("E_busy", bus.busy, 0);
      bus.in_valid = 1'b0;
      tick();
      tick();
      #2 rst = 1'b0;
      tick();
      do_clear("clr4_busy");
      send_hv(1'b0, c, -1);
      chk("E_cnt_spam", bus.cnt_spam, 1);
      chk("E_cnt_ham2", bus.cnt_ham, 0);
      e = '{1, 1, 1, 1, 1, 1, 1, 1};
      dump_chk("E_spam", 1'b0, e, 1'b0);
      e = '{0, 0, 0, 0, 0, 0, 0, 0};
      dump_chk("E_ham", 1'b1, e, 1'b1);

      // Reset in the middle of a dump drops out_valid at once
      bus.dump_class = 1'b0;
      bus.dump_start = 1'b1;
      tick();
      bus.dump_start = 1'b0;
      bus.out_ready  = 1'b1;
      tick();
      tick();
      chk("F_vld_mid", bus.out_valid, 1);
      chk("F_data_mid", $signed(bus.out_data), 1);
      #2 rst = 1'b1;
      #1;
      chk("F_out_valid", bus.out_valid, 0);
      chk("F_out_last", bus.out_last, 0);
      chk("F_busy", bus.busy, 0);
      bus.out_ready = 1'b0;
      tick();
      #2 rst = 1'b0;
      tick();
      chk("F_out_valid_post", bus.out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hdc_class_trainer.md
# hdc_class_trainer

Training-side counterpart to the HDC message classifier: it accepts encoded message hypervectors (bipolar/ternary elements, one per cycle) tagged with a class label, and bundles them into per-class accumulator memories. On command it streams a class accumulator back out, element by element, so the classifier's ham/spam reference vectors can be built or refreshed in the design. It sits between the message encoder's HV output and the reference-vector load path.

## Interface
- DIM, 10000, hypervector dimension (elements per HV)
- ACC_W, 16, accumulator width per element, signed
- CNT_W, 16, width of per-class sample counters
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- clear_start  in  1  pulse: zero both class accumulators
- dump_start  in  1  pulse: stream accumulator of dump_class
- dump_class  in  1  class to dump (1 = ham, 0 = spam), sampled with dump_start
- in_valid  in  1  element valid
- in_ready  out  1  element accepted when in_valid && in_ready
- in_elem  in  2  element code: 01 = +1, 11 = -1, 00 = 0, 10 = 0 (illegal, flagged)
- in_label  in  1  class of the HV (1 = ham, 0 = spam), sampled on element 0 only
- out_valid  out  1  dump word valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  ACC_W  signed accumulator value of current element
- out_last  out  1  high with element DIM-1 of a dump
- busy  out  1  state != IDLE
- bad_elem  out  1  sticky: an element with code 10 was accepted; cleared by clear_start or reset
- cnt_ham, cnt_spam  out  CNT_W  HVs fully trained per class, saturating

## Operation
- States: IDLE, CLEAR, TRAIN, DUMP. Index register idx (0..DIM-1), label register lab.
- IDLE priority: clear_start > dump_start > in_valid. Command inputs ignored outside IDLE.
- CLEAR: DIM cycles; cycle k writes 0 to acc_ham[k] and acc_spam[k]; after idx = DIM-1 -> IDLE. Also zeroes cnt_ham, cnt_spam, bad_elem on entry.
- TRAIN entry: in IDLE an accepted element is element 0: lab <= in_label, acc_lab[0] updated, idx <= 1, -> TRAIN. If DIM = 1, stays IDLE and counts the sample.
- TRAIN: each accepted element j: acc_lab[j] <= sat(acc_lab[j] + e); idx increments; on accepting idx = DIM-1 -> IDLE, counter for lab += 1 (saturates at 2^CNT_W-1). Cycles without in_valid hold state (gaps allowed, no timeout).
- Saturation: result clamped to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)]; the most negative code is never produced.
- DUMP: reads acc_class[idx] for idx = 0..DIM-1 into out_data; advance only on out_valid && out_ready; transfer of idx = DIM-1 (out_last = 1) -> IDLE.
- Accumulator memory is not reset; contents undefined after reset until a CLEAR completes.

## Timing
- Reset values: state IDLE, idx 0, in_ready 1, out_valid 0, out_data 0, out_last 0, busy 0, bad_elem 0, cnt_ham 0, cnt_spam 0.
- in_ready = (IDLE && !clear_start && !dump_start) || TRAIN; combinational; 0 in CLEAR and DUMP.
- Accumulate: one element per cycle throughput; write lands at the end of the accept cycle; no read-after-write hazard (distinct index per cycle).
- Counter increments in the same cycle as acceptance of the last element; visible the next cycle.
- Dump latency: dump_start in cycle N -> out_valid = 1 with element 0 in cycle N+1. out_data/out_last held stable while out_valid && !out_ready. Back-to-back transfers at full rate when out_ready held high.
- CLEAR takes exactly DIM cycles; busy high from the cycle after clear_start until return to IDLE.
- Reset mid-TRAIN/DUMP/CLEAR: immediate return to IDLE, partial HV discarded (counter not incremented), out_valid drops asynchronously.

## Test plan
- DIM=8: reset, clear, then train one ham HV of all +1 -> dump ham yields eight words of +1, out_last only on 8th, cnt_ham = 1, cnt_spam = 0.
- Train spam HV {+1,-1,0,+1,-1,0,+1,-1} twice, ham HV all -1 once -> spam dump {2,-2,0,2,-2,0,2,-2}, ham dump all -1; ham accumulator unaffected by spam training.
- ACC_W=4: train 9 ham HVs all +1 -> every ham element 7 (saturated); then 16 HVs all -1 -> every element -7, never -8.
- Dump with out_ready toggling 1,0,0,1,... -> every element delivered exactly once, in order, data stable during stalls; in_valid during DUMP sees in_ready = 0.
- Same-cycle clear_start, dump_start and in_valid in IDLE -> CLEAR entered, element not accepted (in_ready = 0), busy for 8 cycles; element code 10 accepted later -> bad_elem = 1, accumulator adds 0.
- Assert reset at element 4 of a ham HV -> cnt_ham stays 0, in_ready = 1, out_valid = 0 immediately; next HV starts at element 0 with a fresh label.
